// File: rtl/scan_select_sequencer_if.sv
// -----------------------------------------------------------------------------
// scan_select_sequencer_if
// Bundles the control inputs and the registered select outputs of
// scan_select_sequencer.
//   master : drives en, hold, dir, load, load_sel, skip_mask; observes outputs
//   slave  : the sequencer itself; drives S1, S0, slot_valid, wrap
// Signals:
//   en         scan enable (0 forces IDLE)
//   hold       pause, freezes slot and dwell counter
//   dir        0 = up, 1 = down
//   load       synchronous slot load strobe
//   load_sel   slot value applied on load
//   skip_mask  bit i = 1 excludes slot i (honoured only with SCAN_SKIP_EN)
//   S1, S0     registered select lines to the 2-to-4 decoder
//   slot_valid current slot is active and unmasked
//   wrap       one-cycle pulse when the scan crosses the 3/0 boundary
// -----------------------------------------------------------------------------
interface scan_select_sequencer_if;
   logic       en;
   logic       hold;
   logic       dir;
   logic       load;
   logic [1:0] load_sel;
   logic [3:0] skip_mask;
   logic       S1;
   logic       S0;
   logic       slot_valid;
   logic       wrap;

   modport master (
      output en, hold, dir, load, load_sel, skip_mask,
      input  S1, S0, slot_valid, wrap
   );

   modport slave (
      input  en, hold, dir, load, load_sel, skip_mask,
      output S1, S0, slot_valid, wrap
   );
endinterface

// File: rtl/scan_select_sequencer.sv
// -----------------------------------------------------------------------------
// scan_select_sequencer
// Registered 2-bit select generator for a 2-to-4 decoder. Steps through the
// four slots in a time-multiplexed scan, holding each slot for DWELL cycles,
// with up/down direction, pause, synchronous slot load and optional per-slot
// skipping. All outputs come straight from flops so the decoder select lines
// are glitch-free.
//
// Parameters:
//   DWELL  cycles each slot is held (1..65535)
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   sif    scan_select_sequencer_if.slave (controls in, select/status out)
// Build option:
//   SCAN_SKIP_EN  when defined, skip_mask excludes slots from the scan; when
//                 undefined, skip_mask is ignored and all slots are visited.
// -----------------------------------------------------------------------------
module scan_select_sequencer #(
   parameter int DWELL = 4
) (
   input logic                     clk,
   input logic                     rst,
   scan_select_sequencer_if.slave  sif
);

   localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          wrap_q, wrap_d;
   logic [3:0]    mask;
   logic          nxt_found;
   logic [1:0]    nxt_sel;

`ifdef SCAN_SKIP_EN
   assign mask = sif.skip_mask;
`else
   assign mask = 4'b0000;
   logic unused_skip_mask;
   assign unused_skip_mask = ^sif.skip_mask;
`endif

   // Search offsets +1, +2, +3 in the scan direction and return the first
   // unmasked slot. When nothing is found the current slot is returned, which
   // covers both "only the current slot is live" (dwell simply restarts) and
   // "everything masked" (sel holds, slot_valid goes low).
   function automatic logic [2:0] next_slot(input logic [1:0] cur,
                                            input logic       down,
                                            input logic [3:0] m);
      logic       found;
      logic [1:0] slot;
      logic [1:0] cand;
      found = 1'b0;
      slot  = cur;
      for (int k = 1; k <= 3; k++) begin
         cand = down ? (cur - 2'(k)) : (cur + 2'(k));
         if (!found && !m[cand]) begin
            found = 1'b1;
            slot  = cand;
         end
      end
      return {found, slot};
   endfunction

   assign {nxt_found, nxt_sel} = next_slot(sel_q, sif.dir, mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   // Priority: load > en=0 > hold > dwell advance.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;

      if (sif.load) begin
         sel_d   = sif.load_sel;
         cnt_d   = '0;
         if (sif.en) begin
            state_d = RUN;
            valid_d = !mask[sif.load_sel];
         end else begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      end else if (!sif.en) begin
         state_d = IDLE;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Entry presents the current slot immediately; the first
               // advance comes DWELL edges later.
               state_d = RUN;
               cnt_d   = '0;
               valid_d = !mask[sel_q];
            end
            RUN, PAUSE: begin
               if (sif.hold) begin
                  // Every edge that samples hold=1 is frozen; the edge that
                  // samples hold=0 resumes counting, so a pause of N cycles
                  // stretches the dwell by exactly N.
                  state_d = PAUSE;
               end else begin
                  state_d = RUN;
                  if (cnt_q == CNT_LAST) begin
                     cnt_d  = '0;
                     sel_d  = nxt_sel;
                     wrap_d = sif.dir ? (nxt_sel > sel_q) : (nxt_sel < sel_q);
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  valid_d = !mask[sel_d];
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign sif.S1         = sel_q[1];
   assign sif.S0         = sel_q[0];
   assign sif.slot_valid = valid_q;
   assign sif.wrap       = wrap_q;

endmodule

// File: doc/scan_select_sequencer.md
# scan_select_sequencer

Registered 2-bit select generator that drives the S1/S0 inputs of the 2-to-4 decoder stage, stepping through the four decoder outputs in a time-multiplexed scan (display digit scan, bank strobing). Each slot is held for a programmable dwell time. The block supports up or down direction, pause, a synchronous slot load and per-slot skipping. All outputs are registered, so the downstream decoder sees glitch-free select lines.

## Interface
- DWELL, 4, cycles each slot is held; legal range 1..65535
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable; 0 forces IDLE
- hold  in  1  pause; freezes the slot and the dwell counter
- dir  in  1  scan direction; 0 = up (0→1→2→3→0), 1 = down
- load  in  1  synchronous slot load strobe
- load_sel  in  2  slot value applied on load
- skip_mask  in  4  bit i = 1 excludes slot i (only under SCAN_SKIP_EN)
- S1  out  1  select MSB to the decoder
- S0  out  1  select LSB to the decoder
- slot_valid  out  1  current slot is active and unmasked
- wrap  out  1  one-cycle pulse on the update that crosses the 3/0 boundary

## Operation
- Internal state: sel[1:0] (drives {S1,S0}), dwell counter cnt of width max(1,$clog2(DWELL)), FSM state.
- FSM states are IDLE, RUN and PAUSE.
  - IDLE→RUN when en=1.
  - RUN→PAUSE when hold=1; PAUSE→RUN when hold=0.
  - Any state→IDLE when en=0.
- Per-edge priority: rst > load > en=0 > hold > dwell advance.
- load=1 (any state, en ignored):
  - sel←load_sel, cnt←0.
  - State becomes RUN if en=1, otherwise IDLE.
  - No wrap pulse.
- IDLE: sel holds its last value, cnt←0, slot_valid=0.
- PAUSE: sel and cnt frozen; slot_valid unchanged.
- RUN behaviour:
  - cnt increments each cycle.
  - When cnt==DWELL-1: cnt←0 and sel←next slot.
  - Next slot: search offsets +1, +2, +3 in the current direction, modulo 4; take the first unmasked slot.
  - If none is found and the current slot is unmasked, sel stays and the dwell restarts.
  - If all four slots are masked, sel holds and slot_valid=0.
- wrap=1 for exactly the cycle in which the new sel is presented, and only when:
  - up direction and new sel < old sel, or
  - down direction and new sel > old sel.
- slot_valid (registered) = state∈{RUN,PAUSE} and skip_mask[sel]==0, evaluated on the next sel.
- A dir change takes effect at the next advance; the dwell is not restarted.
- skip_mask changes mid-dwell:
  - If the current slot becomes masked, slot_valid drops on the next edge.
  - The slot still dwells to terminal count, then advances.

## Timing
- Reset values: S1=0, S0=0, slot_valid=0, wrap=0, cnt=0, state IDLE.
- Entry: en sampled 1 at edge k → state RUN and slot_valid=1 at edge k, with sel unchanged (0 after reset).
- Dwell: with en=1 held, sel changes every DWELL cycles. The first change occurs DWELL edges after RUN entry.
- DWELL=1: sel advances on every RUN edge.
- load: the sel update is visible one edge after the load strobe is sampled.
- Reset asserted mid-scan: outputs clear immediately (asynchronously), without waiting for clk. Operation restarts in IDLE after deassertion.

## Configuration
- SCAN_SKIP_EN defined: skip_mask is honoured exactly as described in Operation.
- SCAN_SKIP_EN undefined:
  - skip_mask is ignored (treated as 4'b0000); the port remains present and is unused.
  - slot_valid = state∈{RUN,PAUSE}.
  - The scan always visits all four slots.

## Test plan
- Reset then en=1, dir=0, DWELL=4, mask 0 → sel 0,1,2,3,0 at 4-cycle intervals; wrap pulses once as sel returns to 0; slot_valid=1 throughout.
- dir=1 from sel=0 → next sel 3 with a wrap pulse, then 2, 1, 0.
- hold=1 for 5 cycles mid-dwell at sel=2 → sel stays 2; after release, the remaining dwell cycles complete before sel=3.
- load=1, load_sel=2 while en=0 → sel=2, state IDLE, slot_valid=0, wrap=0. Then en=1 → scan resumes from 2.
- SCAN_SKIP_EN, skip_mask=4'b0101, up, DWELL=2 → sel sequence 1,3,1,3; wrap on each 3→1. Then skip_mask=4'b1111 → slot_valid=0 and sel frozen.
- rst asserted mid-dwell at sel=3 → S1=S0=0, slot_valid=0, wrap=0 immediately, without waiting for a clock edge.
